// File: rtl/aplic_msi_notifier.sv
// MSI delivery stage of one APLIC interrupt domain: round-robin source scan,
// genmsi service, pending-clear pulses and a valid/ready MSI write port.
module aplic_msi_notifier #(
  parameter int NrSources  = 32,
  parameter int NrSourcesW = $clog2(NrSources),
  parameter int HartIdxW   = 14,
  parameter int EiidW      = 11
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_domain_ie,
  input  logic [NrSources-1:0]           i_pending,
  input  logic [NrSources-1:0]           i_enabled,
  input  logic [NrSources*HartIdxW-1:0]  i_target_hi,
  input  logic [NrSources*EiidW-1:0]     i_target_eiid,
  input  logic [63:0]                    i_msi_base,
  input  logic [2:0]                     i_lhxs,
  input  logic                           i_genmsi_wr,
  input  logic [HartIdxW-1:0]            i_genmsi_hi,
  input  logic [EiidW-1:0]               i_genmsi_eiid,
  output logic                           o_genmsi_busy,
  output logic                           o_clr_pending_valid,
  output logic [NrSourcesW-1:0]          o_clr_pending_idx,
  output logic                           o_msi_valid,
  output logic [63:0]                    o_msi_addr,
  output logic [31:0]                    o_msi_data,
  input  logic                           i_msi_ready
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [NrSourcesW-1:0] LastIdx  = NrSourcesW'(NrSources - 1);
  localparam logic [NrSourcesW-1:0] FirstIdx = NrSourcesW'(1);

  state_t                state, next_state;
  logic [NrSourcesW-1:0] rr_ptr;
  logic                  busy;
  logic [HartIdxW-1:0]   gen_hi;
  logic [EiidW-1:0]      gen_eiid;
  logic                  is_gen;
  logic                  clr_valid;
  logic [NrSourcesW-1:0] clr_idx;
  logic [63:0]           msi_addr;
  logic [31:0]           msi_data;

  logic [NrSources-1:0]  cand;
  logic                  found;
  logic [NrSourcesW-1:0] sel;
  int                    idx;
  logic [HartIdxW-1:0]   sel_hi;
  logic [EiidW-1:0]      sel_eiid;
  logic                  take_gen;
  logic                  take_src;
  logic [HartIdxW-1:0]   send_hi;
  logic [EiidW-1:0]      send_eiid;
  logic [63:0]           next_addr;
  logic                  handshake;

  // The source cleared last cycle is masked: the register file only drops its ip one cycle later.
  always_comb begin
    cand    = i_pending & i_enabled & {NrSources{i_domain_ie}};
    cand[0] = 1'b0;
    if (clr_valid) cand[clr_idx] = 1'b0;
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int off = 0; off < NrSources - 1; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NrSources) idx = idx - (NrSources - 1);
      if (!found && cand[idx[NrSourcesW-1:0]]) begin
        found = 1'b1;
        sel   = NrSourcesW'(idx);
      end
    end
  end

  always_comb begin
    sel_hi    = i_target_hi[sel*HartIdxW +: HartIdxW];
    sel_eiid  = i_target_eiid[sel*EiidW +: EiidW];
    take_gen  = (state == IDLE) && busy;
    take_src  = (state == IDLE) && !busy && found;
    send_hi   = take_gen ? gen_hi : sel_hi;
    send_eiid = take_gen ? gen_eiid : sel_eiid;
    next_addr = i_msi_base +
                ({{(64-HartIdxW){1'b0}}, send_hi} << (7'd12 + {4'b0, i_lhxs}));
  end

  // State register together with the captured MSI fields, genmsi latch and rr pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rr_ptr    <= FirstIdx;
      busy      <= 1'b0;
      gen_hi    <= '0;
      gen_eiid  <= '0;
      is_gen    <= 1'b0;
      clr_valid <= 1'b0;
      clr_idx   <= '0;
      msi_addr  <= '0;
      msi_data  <= '0;
    end else begin
      state     <= next_state;
      clr_valid <= take_src;
      if (take_src) begin
        clr_idx <= sel;
        rr_ptr  <= (sel == LastIdx) ? FirstIdx : sel + 1'b1;
      end
      if (state == IDLE && next_state == SEND) begin
        msi_addr <= next_addr;
        msi_data <= {{(32-EiidW){1'b0}}, send_eiid};
        is_gen   <= take_gen;
      end
      if (handshake && is_gen) busy <= 1'b0;
      if (i_genmsi_wr && !busy) begin
        busy     <= 1'b1;
        gen_hi   <= i_genmsi_hi;
        gen_eiid <= i_genmsi_eiid;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (take_gen || (take_src && sel_eiid != '0)) next_state = SEND;
      SEND: if (i_msi_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_msi_valid         = (state == SEND);
    o_msi_addr          = msi_addr;
    o_msi_data          = msi_data;
    o_genmsi_busy       = busy;
    o_clr_pending_valid = clr_valid;
    o_clr_pending_idx   = clr_idx;
    handshake           = (state == SEND) && i_msi_ready;
  end

endmodule

// File: tb/tb_aplic_msi_notifier.sv
// Self-checking bench for aplic_msi_notifier: vector table plus hand-written
// multi-cycle sequences, with an MSI scoreboard and a register-file model.
module tb_aplic_msi_notifier;

  localparam int NS = 32;
  localparam int HW = 14;
  localparam int EW = 11;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_domain_ie;
  logic [NS-1:0]   pend;
  logic [NS-1:0]   i_enabled;
  logic [NS*HW-1:0] i_target_hi;
  logic [NS*EW-1:0] i_target_eiid;
  logic [63:0]     i_msi_base;
  logic [2:0]      i_lhxs;
  logic            i_genmsi_wr;
  logic [HW-1:0]   i_genmsi_hi;
  logic [EW-1:0]   i_genmsi_eiid;
  logic            o_genmsi_busy;
  logic            o_clr_pending_valid;
  logic [4:0]      o_clr_pending_idx;
  logic            o_msi_valid;
  logic [63:0]     o_msi_addr;
  logic [31:0]     o_msi_data;
  logic            i_msi_ready;

  aplic_msi_notifier #(.NrSources(NS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_domain_ie(i_domain_ie),
    .i_pending(pend), .i_enabled(i_enabled),
    .i_target_hi(i_target_hi), .i_target_eiid(i_target_eiid),
    .i_msi_base(i_msi_base), .i_lhxs(i_lhxs),
    .i_genmsi_wr(i_genmsi_wr), .i_genmsi_hi(i_genmsi_hi), .i_genmsi_eiid(i_genmsi_eiid),
    .o_genmsi_busy(o_genmsi_busy),
    .o_clr_pending_valid(o_clr_pending_valid), .o_clr_pending_idx(o_clr_pending_idx),
    .o_msi_valid(o_msi_valid), .o_msi_addr(o_msi_addr), .o_msi_data(o_msi_data),
    .i_msi_ready(i_msi_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } msi_t;

  typedef struct {
    int          src;
    logic [13:0] hi;
    logic [10:0] eiid;
    logic [63:0] base;
    logic [2:0]  lhxs;
    logic [63:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  msi_t exp_q[$];
  int   clr_log[$];
  int   pass_cnt = 0;
  int   total    = 0;
  int   msi_seen = 0;
  bit   repend   = 1'b0;
  vec_t vecs[5];

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock: scoreboard and register-file model sample mid-cycle, clears land after the edge.
  task automatic tick();
    bit       do_clr;
    int       clr_at;
    msi_t     e;
    do_clr = 1'b0;
    clr_at = 0;
    @(negedge i_clk);
    if (o_msi_valid === 1'b1 && i_msi_ready) begin
      msi_seen++;
      if (exp_q.size() == 0) begin
        check_output("unexpected_msi_addr", o_msi_addr, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check_output("msi_addr", o_msi_addr, e.addr);
        check_output("msi_data", {32'h0, o_msi_data}, {32'h0, e.data});
      end
    end
    if (o_clr_pending_valid === 1'b1) begin
      clr_log.push_back(int'(o_clr_pending_idx));
      if (!repend) begin
        do_clr = 1'b1;
        clr_at = int'(o_clr_pending_idx);
      end
    end
    @(posedge i_clk);
    #1;
    if (do_clr) pend[clr_at] = 1'b0;
  endtask

  task automatic wait_msis(int target, int budget, string name);
    int n;
    n = 0;
    while (msi_seen < target && n < budget) begin
      tick();
      n++;
    end
    check_output(name, 64'(msi_seen), 64'(target));
  endtask

  task automatic set_target(int k, logic [13:0] hi, logic [10:0] eiid);
    i_target_hi[k*HW +: HW]   = hi;
    i_target_eiid[k*EW +: EW] = eiid;
  endtask

  task automatic apply_stimulus_push(logic [63:0] addr, logic [31:0] data);
    msi_t m;
    m.addr = addr;
    m.data = data;
    exp_q.push_back(m);
  endtask

  task automatic genmsi_write(logic [13:0] hi, logic [10:0] eiid);
    i_genmsi_wr   = 1'b1;
    i_genmsi_hi   = hi;
    i_genmsi_eiid = eiid;
  endtask

  initial begin
    int    base_cnt;
    int    clr_cnt;
    bit    stable;
    logic [63:0] held_addr;
    logic [31:0] held_data;

    vecs[0] = '{5,  14'd3,      11'h2A,  64'h0000_0000_2800_0000, 3'd0, 64'h0000_0000_2800_3000, 32'h2A};
    vecs[1] = '{31, 14'h3FFF,   11'h7FF, 64'h0000_0000_0000_1000, 3'd7, 64'h0000_0001_FFF8_1000, 32'h7FF};
    vecs[2] = '{1,  14'd0,      11'h001, 64'hFFFF_FFFF_FFFF_F000, 3'd0, 64'hFFFF_FFFF_FFFF_F000, 32'h1};
    vecs[3] = '{17, 14'd1,      11'h005, 64'hFFFF_FFFF_FFFF_F000, 3'd0, 64'h0000_0000_0000_0000, 32'h5};
    vecs[4] = '{12, 14'h155,    11'h400, 64'h8000_0000_0000_0000, 3'd3, 64'h8000_0000_00AA_8000, 32'h400};

    i_rst = 1'b1; i_domain_ie = 1'b1; pend = '0; i_enabled = '1;
    i_target_hi = '0; i_target_eiid = '0; i_msi_base = 64'h2800_0000; i_lhxs = 3'd0;
    i_genmsi_wr = 1'b0; i_genmsi_hi = '0; i_genmsi_eiid = '0; i_msi_ready = 1'b1;

    tick(); tick();
    check_output("rst_valid", {63'h0, o_msi_valid}, 64'h0);
    check_output("rst_addr", o_msi_addr, 64'h0);
    check_output("rst_data", {32'h0, o_msi_data}, 64'h0);
    check_output("rst_busy", {63'h0, o_genmsi_busy}, 64'h0);
    check_output("rst_clr", {63'h0, o_clr_pending_valid}, 64'h0);
    check_output("rst_clr_idx", {59'h0, o_clr_pending_idx}, 64'h0);
    i_rst = 1'b0;
    tick();

    // Single-source vectors: latency, address arithmetic and return to IDLE
    for (int v = 0; v < 5; v++) begin
      i_msi_base = vecs[v].base;
      i_lhxs     = vecs[v].lhxs;
      set_target(vecs[v].src, vecs[v].hi, vecs[v].eiid);
      apply_stimulus_push(vecs[v].exp_addr, vecs[v].exp_data);
      pend[vecs[v].src] = 1'b1;
      tick();
      check_output($sformatf("vec%0d_valid", v), {63'h0, o_msi_valid}, 64'h1);
      check_output($sformatf("vec%0d_clr", v), {63'h0, o_clr_pending_valid}, 64'h1);
      check_output($sformatf("vec%0d_clr_idx", v), {59'h0, o_clr_pending_idx}, 64'(vecs[v].src));
      tick();
      check_output($sformatf("vec%0d_idle", v), {63'h0, o_msi_valid}, 64'h0);
      check_output($sformatf("vec%0d_sb_empty", v), 64'(exp_q.size()), 64'h0);
    end

    // Round-robin with re-pending sources 2 and 7, and source 0 pending
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    i_msi_base = 64'h0; i_lhxs = 3'd0;
    set_target(2, 14'd2, 11'd2);
    set_target(7, 14'd7, 11'd7);
    set_target(0, 14'd9, 11'd9);
    repeat (2) begin
      apply_stimulus_push(64'h2000, 32'd2);
      apply_stimulus_push(64'h7000, 32'd7);
    end
    clr_log.delete();
    base_cnt = msi_seen;
    repend = 1'b1;
    pend[0] = 1'b1; pend[2] = 1'b1; pend[7] = 1'b1;
    wait_msis(base_cnt + 4, 40, "rr_count");
    pend = '0;
    repend = 1'b0;
    tick(); tick();
    check_output("rr_clr_count", 64'(clr_log.size()), 64'd4);
    if (clr_log.size() == 4) begin
      check_output("rr_order0", 64'(clr_log[0]), 64'd2);
      check_output("rr_order1", 64'(clr_log[1]), 64'd7);
      check_output("rr_order2", 64'(clr_log[2]), 64'd2);
      check_output("rr_order3", 64'(clr_log[3]), 64'd7);
    end
    check_output("rr_sb_empty", 64'(exp_q.size()), 64'h0);

    // genmsi from IDLE: busy one cycle after the write, valid the cycle after that
    i_msi_base = 64'h2800_0000;
    i_msi_ready = 1'b0;
    genmsi_write(14'd1, 11'h10);
    tick();
    i_genmsi_wr = 1'b0;
    check_output("gen_busy", {63'h0, o_genmsi_busy}, 64'h1);
    check_output("gen_not_yet", {63'h0, o_msi_valid}, 64'h0);
    tick();
    check_output("gen_valid", {63'h0, o_msi_valid}, 64'h1);
    check_output("gen_no_clr", {63'h0, o_clr_pending_valid}, 64'h0);
    apply_stimulus_push(64'h2800_1000, 32'h10);
    i_msi_ready = 1'b1;
    base_cnt = msi_seen;
    wait_msis(base_cnt + 1, 10, "gen_count");
    check_output("gen_busy_clear", {63'h0, o_genmsi_busy}, 64'h0);

    // Source candidate and genmsi write in the same IDLE cycle: source first
    set_target(8, 14'd0, 11'd8);
    apply_stimulus_push(64'h2800_0000, 32'd8);
    apply_stimulus_push(64'h2800_2000, 32'h22);
    pend[8] = 1'b1;
    genmsi_write(14'd2, 11'h22);
    base_cnt = msi_seen;
    tick();
    i_genmsi_wr = 1'b0;
    check_output("simul_clr_idx", {59'h0, o_clr_pending_idx}, 64'd8);
    wait_msis(base_cnt + 2, 20, "simul_count");

    // Handshake and genmsi write in the same cycle
    set_target(5, 14'd3, 11'h2A);
    apply_stimulus_push(64'h2800_3000, 32'h2A);
    apply_stimulus_push(64'h2800_4000, 32'h44);
    pend[5] = 1'b1;
    base_cnt = msi_seen;
    tick();
    genmsi_write(14'd4, 11'h44);
    tick();
    i_genmsi_wr = 1'b0;
    check_output("hs_gen_busy", {63'h0, o_genmsi_busy}, 64'h1);
    check_output("hs_gen_idle", {63'h0, o_msi_valid}, 64'h0);
    tick();
    check_output("hs_gen_valid", {63'h0, o_msi_valid}, 64'h1);
    wait_msis(base_cnt + 2, 10, "hs_gen_count");

    // Backpressure with genmsi queued behind a stalled source MSI
    i_msi_ready = 1'b0;
    set_target(9, 14'd0, 11'd9);
    apply_stimulus_push(64'h2800_3000, 32'h2A);
    apply_stimulus_push(64'h2800_1000, 32'h10);
    apply_stimulus_push(64'h2800_0000, 32'd9);
    pend[5] = 1'b1;
    tick();
    held_addr = o_msi_addr;
    held_data = o_msi_data;
    check_output("bp_valid", {63'h0, o_msi_valid}, 64'h1);
    check_output("bp_addr", held_addr, 64'h2800_3000);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) genmsi_write(14'd1, 11'h10);
      if (c == 4) genmsi_write(14'd9, 11'h33);
      if (c == 5) i_domain_ie = 1'b0;
      if (c == 7) pend[9] = 1'b1;
      tick();
      i_genmsi_wr = 1'b0;
      if (o_msi_valid !== 1'b1 || o_msi_addr !== held_addr || o_msi_data !== held_data)
        stable = 1'b0;
    end
    check_output("bp_stable", {63'h0, stable}, 64'h1);
    check_output("bp_busy", {63'h0, o_genmsi_busy}, 64'h1);
    i_domain_ie = 1'b1;
    i_msi_ready = 1'b1;
    base_cnt = msi_seen;
    wait_msis(base_cnt + 3, 20, "bp_count");
    check_output("bp_busy_clear", {63'h0, o_genmsi_busy}, 64'h0);
    check_output("bp_sb_empty", 64'(exp_q.size()), 64'h0);

    // Zero EIID: clear pulse exactly once, no MSI
    set_target(20, 14'd5, 11'd0);
    clr_log.delete();
    base_cnt = msi_seen;
    pend[20] = 1'b1;
    tick();
    check_output("ez_clr", {63'h0, o_clr_pending_valid}, 64'h1);
    check_output("ez_clr_idx", {59'h0, o_clr_pending_idx}, 64'd20);
    check_output("ez_no_valid", {63'h0, o_msi_valid}, 64'h0);
    repeat (5) tick();
    check_output("ez_clr_once", 64'(clr_log.size()), 64'd1);
    check_output("ez_no_msi", 64'(msi_seen), 64'(base_cnt));

    // Domain IE off, and a pending source that is not enabled
    clr_log.delete();
    i_domain_ie = 1'b0;
    set_target(3, 14'd1, 11'd3);
    set_target(4, 14'd1, 11'd4);
    pend[3] = 1'b1; pend[4] = 1'b1;
    repeat (6) tick();
    check_output("ieoff_no_clr", 64'(clr_log.size()), 64'd0);
    i_domain_ie = 1'b1;
    pend[3] = 1'b0;
    i_enabled[4] = 1'b0;
    repeat (4) tick();
    check_output("dis_no_clr", 64'(clr_log.size()), 64'd0);
    check_output("ieoff_no_msi", 64'(msi_seen), 64'(base_cnt));
    pend = '0;
    i_enabled = '1;

    // Reset while an MSI is stalled (level source keeps its ip)
    repend = 1'b1;
    i_msi_ready = 1'b0;
    set_target(6, 14'd0, 11'd6);
    pend[6] = 1'b1;
    tick();
    check_output("rs_valid", {63'h0, o_msi_valid}, 64'h1);
    genmsi_write(14'd7, 11'h77);
    tick();
    i_genmsi_wr = 1'b0;
    tick();
    clr_log.delete();
    i_rst = 1'b1;
    tick();
    check_output("rs_drop_valid", {63'h0, o_msi_valid}, 64'h0);
    check_output("rs_busy", {63'h0, o_genmsi_busy}, 64'h0);
    check_output("rs_addr", o_msi_addr, 64'h0);
    check_output("rs_clr", {63'h0, o_clr_pending_valid}, 64'h0);
    i_rst = 1'b0;
    apply_stimulus_push(64'h2800_0000, 32'd6);
    i_msi_ready = 1'b1;
    base_cnt = msi_seen;
    wait_msis(base_cnt + 1, 10, "rs_resend");
    pend = '0;
    repend = 1'b0;
    repeat (4) tick();
    check_output("rs_only_one", 64'(msi_seen), 64'(base_cnt + 1));
    check_output("rs_sb_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
